// File: rtl/shared_bus_ctrl.sv
// -----------------------------------------------------------------------------
// shared_bus_ctrl
//
// Moves a fixed-length burst from the granted requester (A or B) onto a single
// shared output bus with a valid/ready handshake. When the burst completes, the
// owner's done strobe pulses for one cycle. If the owner's grant drops during
// the transfer, the burst is abandoned and abort pulses instead.
//
// Optional feature: define XFER_TIMEOUT_EN to build a stall counter. A burst
// that stalls for TIMEOUT_CYC consecutive cycles is aborted.
//
// Parameters
//   DATA_W      - requester/bus data width
//   BURST_LEN   - beats per burst (>= 2)
//   TIMEOUT_CYC - stall limit in cycles (>= 1), used only with XFER_TIMEOUT_EN
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   Ga, Gb    in   one-hot grants from the arbiter (A wins if both are high)
//   da, db    in   requester A/B data
//   bus_ready in   downstream accepts the current beat
//   bus_valid out  current beat is valid
//   bus_data  out  current beat data
//   bus_owner out  0 = A, 1 = B; meaningful only while busy
//   busy      out  a burst is in progress (transfer or wrap-up cycle)
//   done_a    out  one-cycle pulse when A's burst completes
//   done_b    out  one-cycle pulse when B's burst completes
//   abort     out  one-cycle pulse when a burst is abandoned
// All outputs are registered.
// -----------------------------------------------------------------------------
module shared_bus_ctrl #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Ga,
   input  logic              Gb,
   input  logic [DATA_W-1:0] da,
   input  logic [DATA_W-1:0] db,
   input  logic              bus_ready,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_owner,
   output logic              busy,
   output logic              done_a,
   output logic              done_b,
   output logic              abort
);

   localparam int unsigned CntW = $clog2(BURST_LEN);

   if (BURST_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("shared_bus_ctrl: BURST_LEN must be >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic                done_a_q, done_a_d;
   logic                done_b_q, done_b_d;
   logic                abort_q, abort_d;

   logic                own_grant;
   logic [DATA_W-1:0]   own_data;
   logic                beat_acc;
   logic                last_beat;
   logic                timeout;

   assign own_grant = owner_q ? Gb : Ga;
   assign own_data  = owner_q ? db : da;
   assign beat_acc  = valid_q & bus_ready;
   assign last_beat = (cnt_q == CntW'(BURST_LEN - 1));

`ifdef XFER_TIMEOUT_EN
   localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);

   logic [StallW-1:0] stall_q, stall_d;

   // Counts consecutive stalled XFER cycles; anything else (accepted beat,
   // grant loss, leaving XFER) clears it.
   always_comb begin
      stall_d = '0;
      timeout = 1'b0;
      if (state_q == StXfer && own_grant && valid_q && !bus_ready) begin
         if (stall_q == StallW'(TIMEOUT_CYC - 1)) begin
            timeout = 1'b1;
         end else begin
            stall_d = stall_q + StallW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      valid_d  = valid_q;
      data_d   = data_q;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      abort_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A wins when both grants are (illegally) high.
            if (Ga) begin
               state_d = StXfer;
               owner_d = 1'b0;
               data_d  = da;
               valid_d = 1'b1;
               cnt_d   = '0;
            end else if (Gb) begin
               state_d = StXfer;
               owner_d = 1'b1;
               data_d  = db;
               valid_d = 1'b1;
               cnt_d   = '0;
            end
         end

         StXfer: begin
            // Grant loss beats a final beat accepted on the same edge.
            if (!own_grant || timeout) begin
               state_d = StIdle;
               abort_d = 1'b1;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else if (beat_acc) begin
               if (last_beat) begin
                  state_d  = StDone;
                  valid_d  = 1'b0;
                  done_a_d = ~owner_q;
                  done_b_d = owner_q;
               end else begin
                  cnt_d  = cnt_q + CntW'(1);
                  data_d = own_data;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         abort_q  <= abort_d;
      end
   end

   assign bus_valid = valid_q;
   assign bus_data  = data_q;
   assign bus_owner = owner_q;
   assign busy      = busy_q;
   assign done_a    = done_a_q;
   assign done_b    = done_b_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_shared_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shared_bus_ctrl
//
// Self-checking bench for shared_bus_ctrl. A transaction-level reference model
// (burst in flight, beats delivered so far, wrap-up cycle) predicts every
// output after each clock edge. Directed scenarios cover reset, the basic A
// and B bursts, stalls, grant drop, simultaneous grants and the stall limit;
// a randomized phase then exercises arbitrary grant/ready/data traffic.
// -----------------------------------------------------------------------------
module tb_shared_bus_ctrl;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned BURST_LEN   = 4;
   localparam int unsigned TIMEOUT_CYC = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              Ga, Gb;
   logic [DATA_W-1:0] da, db;
   logic              bus_ready;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic              bus_owner;
   logic              busy;
   logic              done_a, done_b, abort;

   shared_bus_ctrl #(
      .DATA_W      (DATA_W),
      .BURST_LEN   (BURST_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .Ga        (Ga),
      .Gb        (Gb),
      .da        (da),
      .db        (db),
      .bus_ready (bus_ready),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_owner (bus_owner),
      .busy      (busy),
      .done_a    (done_a),
      .done_b    (done_b),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit                m_in_burst, m_wrap, m_owner;
   bit                m_valid, m_busy, m_done_a, m_done_b, m_abort;
   int                m_beats, m_stalls;
   logic [DATA_W-1:0] m_data;

   // Observation counters for the directed scenarios.
   int                n_done_a, n_done_b, n_abort;
   logic [DATA_W-1:0] acc_q[$];

   function automatic void model_reset();
      m_in_burst = 0; m_wrap = 0; m_owner = 0;
      m_valid = 0; m_busy = 0; m_done_a = 0; m_done_b = 0; m_abort = 0;
      m_beats = 0; m_stalls = 0; m_data = '0;
   endfunction

   function automatic void model_drop();
      m_in_burst = 0;
      m_valid    = 0;
      m_abort    = 1;
   endfunction

   // Advance the model across one clock edge using the inputs present at it.
   function automatic void model_edge();
      bit grant_ok;
      m_done_a = 0; m_done_b = 0; m_abort = 0;
      if (m_wrap) begin
         m_wrap = 0;
      end else if (!m_in_burst) begin
         if (Ga || Gb) begin
            m_in_burst = 1;
            m_owner    = !Ga;
            m_beats    = 0;
            m_stalls   = 0;
            m_data     = Ga ? da : db;
            m_valid    = 1;
         end
      end else begin
         grant_ok = m_owner ? Gb : Ga;
         if (!grant_ok) begin
            model_drop();
         end else if (m_valid && bus_ready) begin
            m_beats++;
            m_stalls = 0;
            if (m_beats == BURST_LEN) begin
               m_in_burst = 0;
               m_wrap     = 1;
               m_valid    = 0;
               if (m_owner) m_done_b = 1;
               else         m_done_a = 1;
            end else begin
               m_data = m_owner ? db : da;
            end
         end
`ifdef XFER_TIMEOUT_EN
         else begin
            m_stalls++;
            if (m_stalls == TIMEOUT_CYC) model_drop();
         end
`endif
      end
      m_busy = m_in_burst || m_wrap;
   endfunction

   task automatic compare();
      check("busy",   32'(busy),      32'(m_busy));
      check("valid",  32'(bus_valid), 32'(m_valid));
      check("done_a", 32'(done_a),    32'(m_done_a));
      check("done_b", 32'(done_b),    32'(m_done_b));
      check("abort",  32'(abort),     32'(m_abort));
      check("excl",   32'(abort & (done_a | done_b)), 32'(0));
      if (m_valid) check("data",  32'(bus_data),  32'(m_data));
      if (m_busy)  check("owner", 32'(bus_owner), 32'(m_owner));
      n_done_a += int'(done_a);
      n_done_b += int'(done_b);
      n_abort  += int'(abort);
   endtask

   // One clock: record a beat if the handshake completes at this edge, advance
   // the model at the edge, compare 1 time unit later.
   task automatic step();
      if (bus_valid && bus_ready) acc_q.push_back(bus_data);
      @(posedge clk);
      if (reset) model_edge();
      #1;
      compare();
   endtask

   task automatic clear_obs();
      n_done_a = 0; n_done_b = 0; n_abort = 0;
      acc_q.delete();
   endtask

   // Asynchronous reset between edges; outputs must clear before any edge.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check({tag, "_valid"}, 32'(bus_valid), 32'(0));
      check({tag, "_data"},  32'(bus_data),  32'(0));
      check({tag, "_owner"}, 32'(bus_owner), 32'(0));
      check({tag, "_busy"},  32'(busy),      32'(0));
      check({tag, "_done"},  32'({done_a, done_b, abort}), 32'(0));
      model_reset();
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   logic [DATA_W-1:0] t2_vals [4];
   bit                t3_pat  [7];
   int                stall_n;

   initial begin
      t2_vals = '{8'h22, 8'h33, 8'h44, 8'h55};
      t3_pat  = '{1, 0, 0, 1, 1, 0, 1};

      reset = 1'b0; Ga = 0; Gb = 0; da = '0; db = '0; bus_ready = 0;
      model_reset();
      async_reset("rst0");
      step();

      // Basic A burst, data changing every cycle.
      clear_obs();
      bus_ready = 1; Ga = 1; da = 8'h11;
      step();
      for (int i = 0; i < 4; i++) begin
         da = t2_vals[i];
         step();
      end
      Ga = 0;
      step();
      check("t2_beats", 32'(acc_q.size()), 32'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < acc_q.size()) check("t2_beat", 32'(acc_q[i]), 32'(8'h11 * (i + 1)));
      end
      check("t2_done_a", 32'(n_done_a), 32'(1));
      check("t2_idle", 32'(busy), 32'(0));

      // B burst with a stalling consumer.
      clear_obs();
      Gb = 1; db = 8'($urandom);
      step();
      for (int i = 0; i < 7; i++) begin
         bus_ready = t3_pat[i];
         db = 8'($urandom);
         step();
      end
      Gb = 0;
      step();
      check("t3_beats", 32'(acc_q.size()), 32'(4));
      check("t3_done_b", 32'(n_done_b), 32'(1));
      check("t3_done_a", 32'(n_done_a), 32'(0));

      // Grant drop after two beats, then B starts from the following IDLE.
      clear_obs();
      bus_ready = 1; Ga = 1; da = 8'hA0;
      step();
      da = 8'hA1; step();
      da = 8'hA2; step();
      Ga = 0; Gb = 1; db = 8'hB0;
      step();
      check("t4_abort", 32'(abort), 32'(1));
      check("t4_idle", 32'(busy), 32'(0));
      step();
      check("t4_b_owner", 32'({busy, bus_owner, bus_valid}), 32'(3'b111));
      check("t4_done_a", 32'(n_done_a), 32'(0));
      Gb = 0;
      step();
      step();

      // Both grants: A owns, B waits until A's done.
      clear_obs();
      Ga = 1; Gb = 1; da = 8'h5A; db = 8'hC3;
      step();
      check("t5_owner_a", 32'(bus_owner), 32'(0));
      for (int i = 0; i < 4; i++) begin
         da = 8'($urandom);
         step();
      end
      check("t5_done_a", 32'(done_a), 32'(1));
      Ga = 0;
      step();
      step();
      check("t5_owner_b", 32'({busy, bus_owner}), 32'(2'b11));
      Gb = 0;
      step();
      step();

      // Reset in the middle of a transfer.
      clear_obs();
      Ga = 1;
      step();
      step();
      async_reset("t1");
      Ga = 0;
      step();
      check("t1_idle", 32'(busy), 32'(0));
      check("t1_no_pulse", 32'(n_done_a + n_abort), 32'(0));

      // Consumer never ready.
      clear_obs();
      bus_ready = 0; Ga = 1;
      step();
      stall_n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         stall_n++;
         if (abort) break;
      end
`ifdef XFER_TIMEOUT_EN
      check("t6_timeout_cyc", 32'(stall_n), 32'(TIMEOUT_CYC));
      check("t6_abort", 32'(n_abort), 32'(1));
`else
      check("t6_still_valid", 32'(bus_valid), 32'(1));
      check("t6_no_abort", 32'(n_abort), 32'(0));
`endif
      Ga = 0;
      step();
      step();

      // Randomized traffic, with requesters usually releasing on done.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) Ga = ~Ga;
         if ($urandom_range(0, 11) == 0) Gb = ~Gb;
         if (done_a && $urandom_range(0, 1) == 1) Ga = 0;
         if (done_b && $urandom_range(0, 1) == 1) Gb = 0;
         bus_ready = ($urandom_range(0, 3) != 0);
         da = 8'($urandom);
         db = 8'($urandom);
         if (c == 1500) async_reset("rnd_rst");
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
